// File: rtl/hmi_pkg.sv
// Shared definitions for the HMI LED path: command mode codes, LED FSM states
// and the pattern rotate helper.
package hmi_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_ROTATE = 2'd3;

  localparam logic [3:0] LVL_FULL = 4'd15;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLASH = 1'b1
  } led_state_e;

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/hmi_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Also used by the key debouncer as its sample strobe.
module hmi_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_sys,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = (presc_q == PRESC_LAST);

endmodule

// File: rtl/hmi_led_drv.sv
// Drives the four board LEDs from host commands (off/static/blink/rotate with
// 16-level PWM) and overrides them with an all-on flash after each event pulse.
module hmi_led_drv
  import hmi_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int FLASH_TICKS = 100
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_pat,
  input  logic [3:0] cmd_lvl,
  input  logic       evt_pulse,
  output logic [3:0] led,
  output logic       flash
);

  localparam int SW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(BLINK_TICKS - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);

  logic tick;

  hmi_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  led_state_e    state_q, state_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_q, flash_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    lvl_q, lvl_d;
  logic [SW-1:0] step_q, step_d;
  logic          phase_q, phase_d;
  logic [3:0]    pwm_q, pwm_d;
  logic [3:0]    led_q, led_d;
  logic [3:0]    pattern;
  logic          pwm_on;
  logic          cmd_xfer;

  assign cmd_rdy  = (state_q == ST_RUN);
  assign cmd_xfer = cmd_vld & cmd_rdy;

  // An event in either state (re)starts the flash window from zero.
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (evt_pulse) begin
          state_d     = ST_FLASH;
          flash_cnt_d = '0;
        end
      end
      ST_FLASH: begin
        if (evt_pulse) begin
          flash_cnt_d = '0;
        end else if (tick) begin
          if (flash_cnt_q == FLASH_LAST) begin
            state_d     = ST_RUN;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q + FW'(1);
          end
        end
      end
      default: begin
        state_d     = ST_RUN;
        flash_cnt_d = '0;
      end
    endcase
    flash_d = (state_d == ST_FLASH);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
    end
  end

  // Blink/rotate keep stepping during a flash so the pattern resumes in phase.
  always_comb begin
    mode_d  = mode_q;
    pat_d   = pat_q;
    lvl_d   = lvl_q;
    step_d  = step_q;
    phase_d = phase_q;
    if (cmd_xfer) begin
      mode_d  = cmd_mode;
      pat_d   = cmd_pat;
      lvl_d   = cmd_lvl;
      step_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (step_q == STEP_LAST) begin
        step_d = '0;
        if (mode_q == MODE_BLINK) begin
          phase_d = ~phase_q;
        end
        if (mode_q == MODE_ROTATE) begin
          pat_d = rotl4(pat_q);
        end
      end else begin
        step_d = step_q + SW'(1);
      end
    end
  end

  always_comb begin
    case (mode_q)
      MODE_STATIC: pattern = pat_q;
      MODE_BLINK:  pattern = phase_q ? 4'h0 : pat_q;
      MODE_ROTATE: pattern = pat_q;
      default:     pattern = 4'h0;
    endcase
    pwm_on = (lvl_q == LVL_FULL) || (pwm_q < lvl_q);
    pwm_d  = pwm_q + 4'd1;
    led_d  = (state_q == ST_FLASH) ? 4'hF : (pattern & {4{pwm_on}});
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      pat_q   <= 4'h0;
      lvl_q   <= LVL_FULL;
      step_q  <= '0;
      phase_q <= 1'b0;
      pwm_q   <= 4'h0;
      led_q   <= 4'h0;
    end else begin
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      lvl_q   <= lvl_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
    end
  end

  assign led   = led_q;
  assign flash = flash_q;

endmodule

// File: tb/tb_hmi_led_drv.sv
// Self-checking bench for hmi_led_drv: a cycle model pushes expected outputs
// into a scoreboard each clock, and feature tasks pop and compare them.
module tb_hmi_led_drv;
  import hmi_pkg::*;

  localparam int TICK_DIV    = 4;
  localparam int BLINK_TICKS = 3;
  localparam int FLASH_TICKS = 2;

  logic       clk_sys   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cmd_vld   = 1'b0;
  logic       cmd_rdy;
  logic [1:0] cmd_mode  = 2'd0;
  logic [3:0] cmd_pat   = 4'h0;
  logic [3:0] cmd_lvl   = 4'h0;
  logic       evt_pulse = 1'b0;
  logic [3:0] led;
  logic       flash;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [5:0] sb_q[$];

  int         m_presc, m_pwm, m_step, m_fcnt, n_fcnt;
  logic [1:0] m_mode;
  logic [3:0] m_pat, m_lvl, m_led, m_shown;
  logic       m_phase, m_flash, n_flash, m_tick, m_pwm_on;

  hmi_led_drv #(
    .TICK_DIV   (TICK_DIV),
    .BLINK_TICKS(BLINK_TICKS),
    .FLASH_TICKS(FLASH_TICKS)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_mode (cmd_mode),
    .cmd_pat  (cmd_pat),
    .cmd_lvl  (cmd_lvl),
    .evt_pulse(evt_pulse),
    .led      (led),
    .flash    (flash)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_reset();
    m_presc = 0; m_pwm = 0; m_step = 0; m_fcnt = 0;
    m_mode = MODE_OFF; m_pat = 4'h0; m_lvl = 4'd15;
    m_phase = 1'b0; m_flash = 1'b0; m_led = 4'h0;
    sb_q.delete();
  endtask

  task automatic model_step();
    m_tick   = (m_presc == TICK_DIV - 1);
    m_pwm_on = (m_lvl == 4'd15) || (m_pwm < int'(m_lvl));
    case (m_mode)
      MODE_STATIC, MODE_ROTATE: m_shown = m_pat;
      MODE_BLINK:               m_shown = m_phase ? 4'h0 : m_pat;
      default:                  m_shown = 4'h0;
    endcase
    m_led = m_flash ? 4'hF : (m_pwm_on ? m_shown : 4'h0);
    n_flash = m_flash;
    n_fcnt  = m_fcnt;
    if (evt_pulse) begin
      n_flash = 1'b1;
      n_fcnt  = 0;
    end else if (m_flash && m_tick) begin
      if (m_fcnt == FLASH_TICKS - 1) n_flash = 1'b0;
      n_fcnt = (m_fcnt + 1) % FLASH_TICKS;
    end
    if (cmd_vld && !m_flash) begin
      m_mode = cmd_mode; m_pat = cmd_pat; m_lvl = cmd_lvl;
      m_step = 0; m_phase = 1'b0;
    end else if (m_tick) begin
      m_step = (m_step + 1) % BLINK_TICKS;
      if (m_step == 0) begin
        if (m_mode == MODE_BLINK)  m_phase = ~m_phase;
        if (m_mode == MODE_ROTATE) m_pat = {m_pat[2:0], m_pat[3]};
      end
    end
    m_flash = n_flash;
    m_fcnt  = n_fcnt;
    m_presc = (m_presc + 1) % TICK_DIV;
    m_pwm   = (m_pwm + 1) % 16;
    sb_q.push_back({m_led, m_flash, ~m_flash});
  endtask

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Called just after a rising edge; drives one cycle and hands back the
  // scoreboard entry for the edge that follows.
  task automatic drive_cycle(input logic vld, input logic evt,
                             output logic [5:0] exp_v, output bit have);
    cmd_vld   = vld;
    evt_pulse = evt;
    @(posedge clk_sys);
    #1;
    cyc++;
    have  = (sb_q.size() != 0);
    exp_v = 6'h0;
    if (have) exp_v = sb_q.pop_front();
  endtask

  task automatic test_reset();
    logic [5:0] exp_v;
    bit         have;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk_sys);
      #1;
      checks++;
      if ({led, flash, cmd_rdy} !== 6'b000001) begin
        failures++;
        $display("[TB] FAIL reset_hold got led=%b flash=%b rdy=%b want led=0000 flash=0 rdy=1", led, flash, cmd_rdy);
      end
    end
    @(negedge clk_sys);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'b0, 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v || {led, flash, cmd_rdy} !== 6'b000001) begin
        failures++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%b model=%b have=%0d want=000001", cyc, {led, flash, cmd_rdy}, exp_v, have);
      end
    end
  endtask

  task automatic test_static();
    logic [5:0] exp_v;
    bit         have;
    cmd_mode = MODE_STATIC; cmd_pat = 4'b1010; cmd_lvl = 4'd15;
    drive_cycle(1'b1, 1'b0, exp_v, have);
    checks++;
    if (!have || {led, flash, cmd_rdy} !== exp_v) begin
      failures++;
      $display("[TB] FAIL static_xfer cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
    end
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b0, 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL static_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      checks++;
      if (led !== 4'b1010) begin
        failures++;
        $display("[TB] FAIL static_led cyc=%0d got=%b want=1010", cyc, led);
      end
    end
  endtask

  task automatic test_blink();
    logic [5:0] exp_v;
    bit         have;
    logic [3:0] prev;
    int         ch[$];
    logic [3:0] vals[$];
    cmd_mode = MODE_BLINK; cmd_pat = 4'hF; cmd_lvl = 4'd15;
    prev = led;
    for (int i = 0; i < 64; i++) begin
      drive_cycle((i == 0), 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL blink_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (led !== prev) begin
        ch.push_back(i);
        vals.push_back(led);
        prev = led;
      end
    end
    checks++;
    if (ch.size() < 5) begin
      failures++;
      $display("[TB] FAIL blink_changes got=%0d want>=5", ch.size());
    end else begin
      checks++;
      if (vals[0] !== 4'hF) begin
        failures++;
        $display("[TB] FAIL blink_first got=%b want=1111", vals[0]);
      end
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (vals[k] !== ((vals[k-1] == 4'hF) ? 4'h0 : 4'hF)) begin
          failures++;
          $display("[TB] FAIL blink_value k=%0d got=%b prev=%b", k, vals[k], vals[k-1]);
        end
        if (k >= 2) begin
          checks++;
          if (ch[k] - ch[k-1] != 12) begin
            failures++;
            $display("[TB] FAIL blink_period k=%0d got=%0d want=12", k, ch[k] - ch[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_rotate();
    logic [5:0] exp_v;
    bit         have;
    logic [3:0] prev;
    int         ch[$];
    logic [3:0] vals[$];
    logic [3:0] rot_exp [5];
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cmd_mode = MODE_ROTATE; cmd_pat = 4'b0001; cmd_lvl = 4'd15;
    prev = led;
    for (int i = 0; i < 72; i++) begin
      drive_cycle((i == 0), 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL rotate_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (led !== prev) begin
        ch.push_back(i);
        vals.push_back(led);
        prev = led;
      end
    end
    checks++;
    if (ch.size() < 5) begin
      failures++;
      $display("[TB] FAIL rotate_changes got=%0d want>=5", ch.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (vals[k] !== rot_exp[k]) begin
          failures++;
          $display("[TB] FAIL rotate_seq k=%0d got=%b want=%b", k, vals[k], rot_exp[k]);
        end
        if (k >= 2) begin
          checks++;
          if (ch[k] - ch[k-1] != 12) begin
            failures++;
            $display("[TB] FAIL rotate_period k=%0d got=%0d want=12", k, ch[k] - ch[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_pwm();
    logic [5:0] exp_v;
    bit         have;
    int         on_cnt;
    cmd_mode = MODE_STATIC; cmd_pat = 4'hF; cmd_lvl = 4'd4;
    on_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle((i == 0), 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL pwm4_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (i >= 4 && led === 4'hF) on_cnt++;
    end
    checks++;
    if (on_cnt != 4) begin
      failures++;
      $display("[TB] FAIL pwm4_duty got=%0d want=4", on_cnt);
    end
    cmd_lvl = 4'd0;
    on_cnt  = 0;
    for (int i = 0; i < 36; i++) begin
      drive_cycle((i == 0), 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL pwm0_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (i >= 4 && led !== 4'h0) on_cnt++;
    end
    checks++;
    if (on_cnt != 0) begin
      failures++;
      $display("[TB] FAIL pwm0_dark got=%0d lit cycles want=0", on_cnt);
    end
  endtask

  task automatic test_flash();
    logic [5:0] exp_v;
    bit         have;
    int         len;
    cmd_mode = MODE_STATIC; cmd_pat = 4'b0001; cmd_lvl = 4'd15;
    for (int i = 0; i < 4; i++) begin
      drive_cycle((i == 0), 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL flash_setup cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
    end
    checks++;
    if (led !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL flash_pre_led got=%b want=0001", led);
    end
    drive_cycle(1'b0, 1'b1, exp_v, have);
    checks++;
    if (!have || {led, flash, cmd_rdy} !== exp_v || flash !== 1'b1 || cmd_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flash_enter cyc=%0d got=%b model=%b want flash=1 rdy=0", cyc, {led, flash, cmd_rdy}, exp_v);
    end
    len = 1;
    for (int i = 0; i < 40 && flash === 1'b1; i++) begin
      drive_cycle(1'b0, 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL flash_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (flash === 1'b1) begin
        len++;
        checks++;
        if (led !== 4'hF || cmd_rdy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL flash_on cyc=%0d got led=%b rdy=%b want led=1111 rdy=0", cyc, led, cmd_rdy);
        end
      end
    end
    checks++;
    if (len < 5 || len > 8) begin
      failures++;
      $display("[TB] FAIL flash_len got=%0d want 5..8", len);
    end
    drive_cycle(1'b0, 1'b0, exp_v, have);
    checks++;
    if (!have || {led, flash, cmd_rdy} !== exp_v || led !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL flash_resume cyc=%0d got=%b model=%b want led=0001", cyc, {led, flash, cmd_rdy}, exp_v);
    end
  endtask

  task automatic test_retrigger();
    logic [5:0] exp_v;
    bit         have;
    int         len;
    cmd_mode = MODE_STATIC; cmd_pat = 4'b1100; cmd_lvl = 4'd15;
    len = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle((i != 0), (i == 0) || (i == 4), exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v || flash !== 1'b1) begin
        failures++;
        $display("[TB] FAIL retrig_start cyc=%0d got=%b model=%b want flash=1", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (flash === 1'b1) len++;
    end
    for (int i = 0; i < 40 && flash === 1'b1; i++) begin
      drive_cycle(1'b1, 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL retrig_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (flash === 1'b1) len++;
    end
    checks++;
    if (len < 9 || len > 12) begin
      failures++;
      $display("[TB] FAIL retrig_len got=%0d want 9..12", len);
    end
    drive_cycle(1'b1, 1'b0, exp_v, have);
    drive_cycle(1'b0, 1'b0, exp_v, have);
    checks++;
    if (!have || {led, flash, cmd_rdy} !== exp_v || led !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL retrig_stalled_cmd cyc=%0d got=%b model=%b want led=1100", cyc, {led, flash, cmd_rdy}, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_v;
    bit         have;
    cmd_mode = MODE_STATIC; cmd_pat = 4'b0110; cmd_lvl = 4'd15;
    drive_cycle(1'b1, 1'b1, exp_v, have);
    checks++;
    if (!have || {led, flash, cmd_rdy} !== exp_v || flash !== 1'b1 || cmd_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_enter cyc=%0d got=%b model=%b want flash=1 rdy=0", cyc, {led, flash, cmd_rdy}, exp_v);
    end
    for (int i = 0; i < 40 && flash === 1'b1; i++) begin
      drive_cycle(1'b0, 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v) begin
        failures++;
        $display("[TB] FAIL b2b_sb cyc=%0d got=%b want=%b", cyc, {led, flash, cmd_rdy}, exp_v);
      end
      if (flash === 1'b1) begin
        checks++;
        if (led !== 4'hF) begin
          failures++;
          $display("[TB] FAIL b2b_flash_led cyc=%0d got=%b want=1111", cyc, led);
        end
      end
    end
    drive_cycle(1'b0, 1'b0, exp_v, have);
    checks++;
    if (!have || {led, flash, cmd_rdy} !== exp_v || led !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL b2b_new_pat cyc=%0d got=%b model=%b want led=0110", cyc, {led, flash, cmd_rdy}, exp_v);
    end
  endtask

  task automatic test_reset_mid_flash();
    logic [5:0] exp_v;
    bit         have;
    drive_cycle(1'b0, 1'b1, exp_v, have);
    drive_cycle(1'b0, 1'b0, exp_v, have);
    cmd_mode = MODE_ROTATE; cmd_pat = 4'b0001; cmd_lvl = 4'd15;
    drive_cycle(1'b1, 1'b0, exp_v, have);
    checks++;
    if (flash !== 1'b1 || cmd_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_pre got flash=%b rdy=%b want flash=1 rdy=0", flash, cmd_rdy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led, flash, cmd_rdy} !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL midrst_async got led=%b flash=%b rdy=%b want led=0000 flash=0 rdy=1", led, flash, cmd_rdy);
    end
    repeat (3) begin
      @(posedge clk_sys);
      #1;
      checks++;
      if ({led, flash, cmd_rdy} !== 6'b000001) begin
        failures++;
        $display("[TB] FAIL midrst_hold got led=%b flash=%b rdy=%b want led=0000 flash=0 rdy=1", led, flash, cmd_rdy);
      end
    end
    @(negedge clk_sys);
    cmd_vld = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b0, exp_v, have);
      checks++;
      if (!have || {led, flash, cmd_rdy} !== exp_v || {led, flash, cmd_rdy} !== 6'b000001) begin
        failures++;
        $display("[TB] FAIL midrst_after cyc=%0d got=%b model=%b want=000001", cyc, {led, flash, cmd_rdy}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_blink();
    test_rotate();
    test_pwm();
    test_flash();
    test_retrigger();
    test_back_to_back();
    test_reset_mid_flash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
